// File: rtl/data_bus_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package data_bus_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    ARB_ST_ARB   = 1'b0,
    ARB_ST_BURST = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DEV = 1'b1
  } owner_t;

endpackage

// File: rtl/data_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and a runtime saturation limit.
module arb_sat_counter
  import data_bus_arb_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != limit)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Data memory port arbiter: CPU MEM stage (default priority) vs. one bus-master device.
// Optional performance counters are enabled by defining DATA_BUS_ARB_PERF_EN.
module data_bus_arbiter
  import data_bus_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dev_req,
  input  logic        dev_we,
  input  logic        dev_last,
  input  logic [31:0] dev_addr,
  input  logic [31:0] dev_wdata,
  output logic        dev_gnt,
  output logic        dev_rvalid,
  output logic [31:0] dev_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DATA_BUS_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_dev_beats
`endif
);

  localparam cnt_t STARVE_MAX = cnt_t'(STARVE_LIMIT);
  localparam cnt_t BEAT_LAST  = cnt_t'(MAX_BURST - 1);
  localparam bit   BURST_EN   = (MAX_BURST > 1);

  arb_state_t state, state_nxt;
  owner_t     owner;
  cnt_t       starve_cnt;
  cnt_t       beat_cnt, beat_nxt;
  logic       cpu_req;

  assign cpu_req   = cpu_read | cpu_write;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    owner = OWN_CPU;
    case (state)
      ARB_ST_ARB:   if (dev_req && (!cpu_req || starve_cnt == STARVE_MAX)) owner = OWN_DEV;
      ARB_ST_BURST: if (dev_req) owner = OWN_DEV;
      default:      owner = OWN_CPU;
    endcase
  end

  // Port mux; outputs stay zero when nobody is requesting.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dev_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (owner == OWN_DEV) begin
      mem_read  = ~dev_we;
      mem_write = dev_we;
      mem_addr  = dev_addr;
      mem_wdata = dev_wdata;
      dev_gnt   = 1'b1;
      cpu_stall = cpu_req;
    end else if (cpu_req) begin
      mem_read  = cpu_read;
      mem_write = cpu_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    case (state)
      ARB_ST_ARB: begin
        if (BURST_EN && dev_gnt && !dev_last) begin
          state_nxt = ARB_ST_BURST;
          beat_nxt  = cnt_t'(1);
        end
      end
      ARB_ST_BURST: begin
        if (!dev_req || (dev_gnt && (dev_last || beat_cnt == BEAT_LAST))) begin
          state_nxt = ARB_ST_ARB;
          beat_nxt  = '0;
        end else if (dev_gnt) begin
          beat_nxt = beat_cnt + cnt_t'(1);
        end
      end
      default: begin
        state_nxt = ARB_ST_ARB;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_ST_ARB;
      beat_cnt   <= '0;
      dev_rvalid <= 1'b0;
      dev_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_nxt;
      dev_rvalid <= dev_gnt & ~dev_we;
      if (dev_gnt && !dev_we) dev_rdata <= mem_rdata;
    end
  end

  arb_sat_counter #(.WIDTH(CNT_W)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (dev_gnt | ~dev_req),
    .inc   (dev_req & ~dev_gnt),
    .limit (STARVE_MAX),
    .count (starve_cnt)
  );

`ifdef DATA_BUS_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_dev_beats    <= '0;
    end else begin
      if (cpu_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (dev_gnt)   perf_dev_beats    <= perf_dev_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed-vector bench for data_bus_arbiter with a small behavioural data memory.
module tb_data_bus_arbiter;
  import data_bus_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dev_req, dev_we, dev_last;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_gnt, dev_rvalid;
  logic [31:0] dev_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DATA_BUS_ARB_PERF_EN
  logic [31:0] perf_stall_cycles, perf_dev_beats;
`endif

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

  data_bus_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dev_req(dev_req), .dev_we(dev_we), .dev_last(dev_last),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_gnt(dev_gnt),
    .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DATA_BUS_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_dev_beats(perf_dev_beats)
`endif
  );

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dwe, dl; logic [31:0] da, dd;
    logic e_stall, e_gnt, e_mr, e_mw; logic [31:0] e_ma, e_md;
    logic chk_crd; logic [31:0] e_crd;
    logic e_rv; logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dwe, input logic dl,
                        input logic [31:0] da, input logic [31:0] dd);
    cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cd;
    dev_req = dr; dev_we = dwe; dev_last = dl; dev_addr = da; dev_wdata = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int beat;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'hCAFE;

    //         cr cw ca     cd        dr dwe dl da     dd     stl gnt mr mw ma     md        chk crd        rv rd
    vecs[0]  = '{1'b0,1'b1,32'h10,32'h1234, 1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,1'b0,1'b1,32'h10,32'h1234, 1'b0,32'h0,    1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,32'h10,32'h0,    1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,1'b1,1'b0,32'h10,32'h0,    1'b1,32'h1234, 1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b0,32'h0, 32'h0,    1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,    1'b0,32'h0,    1'b0,32'h0};
    vecs[3]  = '{1'b0,1'b0,32'h0, 32'h0,    1'b1,1'b0,1'b1,32'h20,32'h0, 1'b0,1'b1,1'b1,1'b0,32'h20,32'h0,    1'b1,32'hCAFE, 1'b1,32'hCAFE};
    vecs[4]  = '{1'b0,1'b0,32'h0, 32'h0,    1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,    1'b0,32'h0,    1'b0,32'h0};
    for (int i = 5; i <= 8; i++)
      vecs[i] = '{1'b1,1'b0,32'h10,32'h0,   1'b1,1'b0,1'b1,32'h20,32'h0, 1'b0,1'b0,1'b1,1'b0,32'h10,32'h0,    1'b1,32'h1234, 1'b0,32'h0};
    vecs[9]  = '{1'b1,1'b0,32'h10,32'h0,    1'b1,1'b0,1'b1,32'h20,32'h0, 1'b1,1'b1,1'b1,1'b0,32'h20,32'h0,    1'b1,32'hCAFE, 1'b1,32'hCAFE};
    vecs[10] = '{1'b1,1'b0,32'h10,32'h0,    1'b1,1'b0,1'b1,32'h20,32'h0, 1'b0,1'b0,1'b1,1'b0,32'h10,32'h0,    1'b1,32'h1234, 1'b0,32'h0};
    vecs[11] = '{1'b0,1'b1,32'h20,32'hBEEF, 1'b1,1'b0,1'b1,32'h20,32'h0, 1'b0,1'b0,1'b0,1'b1,32'h20,32'hBEEF, 1'b0,32'h0,    1'b0,32'h0};
    vecs[12] = '{1'b0,1'b0,32'h0, 32'h0,    1'b1,1'b0,1'b1,32'h20,32'h0, 1'b0,1'b1,1'b1,1'b0,32'h20,32'h0,    1'b1,32'hBEEF, 1'b1,32'hBEEF};
    vecs[13] = '{1'b0,1'b0,32'h0, 32'h0,    1'b1,1'b1,1'b1,32'h30,32'h55,1'b0,1'b1,1'b0,1'b1,32'h30,32'h55,   1'b0,32'h0,    1'b0,32'h0};
    vecs[14] = '{1'b1,1'b0,32'h30,32'h0,    1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,1'b1,1'b0,32'h30,32'h0,    1'b1,32'h55,   1'b0,32'h0};

    // Reset state
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    check("rst_gnt", 32'(dev_gnt), 32'h0);
    check("rst_stall", 32'(cpu_stall), 32'h0);
    check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    tick();
    reset = 1'b0;
    check("rst_rvalid", 32'(dev_rvalid), 32'h0);
    check("rst_rdata", dev_rdata, 32'h0);
    check("rst_state", 32'(dut.state), 32'(ARB_ST_ARB));

    // Table-driven single-cycle vectors
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
             vecs[i].dr, vecs[i].dwe, vecs[i].dl, vecs[i].da, vecs[i].dd);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_gnt", i), 32'(dev_gnt), 32'(vecs[i].e_gnt));
      check($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].e_mr));
      check($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_mw));
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_ma);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_md);
      if (vecs[i].chk_crd) check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      tick();
      check($sformatf("v%0d_rvalid", i), 32'(dev_rvalid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) check($sformatf("v%0d_rdata", i), dev_rdata, vecs[i].e_rd);
    end

    // 12-beat write burst, CPU idle: forced release after 8 beats, immediate re-grant
    beat = 0;
    for (int c = 0; c < 40 && beat < 12; c++) begin
      set_in(0, 0, 0, 0, 1, 1, (beat == 11), 32'h40 + 32'(beat), 32'h100 + 32'(beat));
      @(negedge clk);
      check($sformatf("burst_gnt_c%0d", c), 32'(dev_gnt), 32'h1);
      if (dev_gnt) beat++;
      tick();
      check($sformatf("burst_state_b%0d", beat), 32'(dut.state),
            (beat == 8 || beat == 12) ? 32'(ARB_ST_ARB) : 32'(ARB_ST_BURST));
    end
    check("burst_beats", 32'(beat), 32'd12);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 12; i++) check($sformatf("burst_mem_%0d", i), mem[8'h40 + 8'(i)], 32'h100 + 32'(i));

    // CPU load pending: device starves 4 cycles, bursts 8 beats, then CPU gets the port
    for (int c = 0; c < 13; c++) begin
      set_in(1, 0, 32'h44, 0, 1, 1, 0, 32'h80 + 32'(c), 32'(c));
      @(negedge clk);
      check($sformatf("fr_gnt_c%0d", c), 32'(dev_gnt), 32'((c >= 4) && (c <= 11)));
      check($sformatf("fr_stall_c%0d", c), 32'(cpu_stall), 32'((c >= 4) && (c <= 11)));
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset in the middle of a read burst with a CPU store waiting
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
      @(negedge clk);
      check($sformatf("rb_gnt_c%0d", c), 32'(dev_gnt), 32'h1);
      tick();
    end
    check("rb_rvalid", 32'(dev_rvalid), 32'h1);
    reset = 1'b1;
    set_in(0, 1, 32'h60, 32'h77, 1, 0, 0, 32'h20, 0);
    @(negedge clk);
    check("rb_stall_in_rst", 32'(cpu_stall), 32'h1);
    check("rb_no_store", 32'(mem_write), 32'h0);
    tick();
    reset = 1'b0;
    check("rb_state", 32'(dut.state), 32'(ARB_ST_ARB));
    check("rb_rvalid_clr", 32'(dev_rvalid), 32'h0);
    @(negedge clk);
    check("rb_cpu_first_gnt", 32'(dev_gnt), 32'h0);
    check("rb_cpu_first_stall", 32'(cpu_stall), 32'h0);
    check("rb_cpu_store_we", 32'(mem_write), 32'h1);
    check("rb_cpu_store_addr", mem_addr, 32'h60);
    tick();
    check("rb_mem60", mem[8'h60], 32'h77);
    set_in(0, 0, 0, 0, 1, 0, 1, 32'h20, 0);
    @(negedge clk);
    check("rb_dev_regrant", 32'(dev_gnt), 32'h1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

`ifdef DATA_BUS_ARB_PERF_EN
    do_reset();
    check("perf_stall_rst", perf_stall_cycles, 32'h0);
    check("perf_beats_rst", perf_dev_beats, 32'h0);
    set_in(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 0, 1, 32'h20, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("perf_stall", perf_stall_cycles, 32'd3);
    check("perf_beats", perf_dev_beats, 32'd5);
`else
    do_reset();
    check("final_rvalid", 32'(dev_rvalid), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data memory port between the CPU MEM stage (requester 0) and one external bus master, such as a UART/DMA engine (requester 1).
- Sits between the EX/MEM pipeline register outputs and DataMemory.
- CPU has default priority. A starvation counter guarantees device access.
- The device may burst consecutive beats. While it owns the bus, the whole CPU pipeline is frozen via cpu_stall.

Parameters:
- STARVE_LIMIT, 4: consecutive denied device-request cycles before the device pre-empts the CPU (1..15).
- MAX_BURST, 8: maximum device beats per ownership before forced release (1..16).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_read  in  1  MEM-stage load
- cpu_write  in  1  MEM-stage store
- cpu_addr  in  32  MEM-stage address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data (combinational from mem_rdata)
- cpu_stall  out  1  freeze whole pipeline this cycle
- dev_req  in  1  device access request, held until granted
- dev_we  in  1  device write (1) / read (0)
- dev_last  in  1  this beat ends the device burst
- dev_addr  in  32  device address
- dev_wdata  in  32  device write data
- dev_gnt  out  1  device beat performed this cycle
- dev_rvalid  out  1  registered read data valid
- dev_rdata  out  32  registered read data
- mem_read  out  1  to DataMemory
- mem_write  out  1  to DataMemory
- mem_addr  out  32  to DataMemory
- mem_wdata  out  32  to DataMemory
- mem_rdata  in  32  from DataMemory (combinational read)

Behaviour:
- cpu_req = cpu_read | cpu_write.
- States: ARB, DEV_BURST. Reset -> ARB.
- Reset values: starve_cnt=0, beat_cnt=0, dev_rvalid=0, dev_rdata=0. Combinational outputs are 0 when there are no requests.
- Owner selection is combinational from the registered state:
  - ARB, cpu_req only: CPU owns.
  - ARB, dev_req only: device owns.
  - ARB, both requesting: device owns only if starve_cnt==STARVE_LIMIT, else CPU owns.
  - DEV_BURST: device owns if dev_req, else CPU.
- When CPU owns: mem_* = cpu_*, cpu_stall=0, dev_gnt=0.
- When device owns: mem_read=~dev_we, mem_write=dev_we, mem_addr=dev_addr, mem_wdata=dev_wdata, dev_gnt=1, cpu_stall=cpu_req.
- A stalled CPU store is never written; the CPU holds its request stable and it is performed on a later cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle dev_req & ~dev_gnt.
  - Clears on dev_gnt or ~dev_req.
- ARB -> DEV_BURST: on dev_gnt with dev_last=0 and MAX_BURST>1. beat_cnt <= 1.
- DEV_BURST -> ARB when any of the following holds:
  - dev_gnt & dev_last;
  - dev_gnt & beat_cnt==MAX_BURST-1 (forced release; the device must re-arbitrate for remaining beats);
  - ~dev_req (device abandons the burst).
  - Otherwise beat_cnt increments on each dev_gnt.
- Device read latency is 1: a read grant in cycle N gives dev_rvalid=1 and dev_rdata=mem_rdata(N) in cycle N+1. dev_rvalid is 0 after writes and idle cycles.
- cpu_rdata = mem_rdata always. It is meaningful only when cpu_stall=0.
- Simultaneous CPU store and device read of the same address:
  - If the CPU wins, the device is granted later and sees the new data.
  - If the device wins, it sees the old data.
- Reset mid-burst: same cycle the FSM returns to ARB, counters clear, dev_rvalid drops next edge. The device must re-request.
- Addresses pass through unmodified; no alignment check.

Optional Feature:
- Macro: DATA_BUS_ARB_PERF_EN.
- When defined, adds outputs perf_stall_cycles[31:0] and perf_dev_beats[31:0]:
  - perf_stall_cycles counts cycles with cpu_stall=1.
  - perf_dev_beats counts cycles with dev_gnt=1.
  - Both are wrapping 32-bit counters, cleared by reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package data_bus_arb_pkg holds:
  - state encoding ARB_ST_ARB=1'b0, ARB_ST_BURST=1'b1;
  - owner encoding OWN_CPU/OWN_DEV;
  - counter width constants (4 bits for starve_cnt and beat_cnt).
- One natural sub-module: arb_sat_counter (saturating up-counter with clear and limit inputs), used for starve_cnt.

Test Plan:
- Only the CPU requests, store 0x1234 to 0x10 then load 0x10 -> mem_write 1 cycle, cpu_rdata=0x1234, cpu_stall never asserts.
- CPU idle, device read 0x20 (mem holds 0xCAFE) with dev_last=1 -> dev_gnt same cycle, dev_rvalid=1 and dev_rdata=0xCAFE next cycle, FSM stays ARB.
- CPU requests every cycle, device requests from cycle 0, STARVE_LIMIT=4 -> dev_gnt first in cycle 4, cpu_stall=1 exactly that cycle, starve_cnt back to 0.
- CPU idle, device 12-beat write burst with dev_last only on beat 12, MAX_BURST=8 -> grants in cycles 0–7, forced release, beats 9–12 granted after re-arbitration, with dev_last on beat 12 returning the FSM to ARB.
- Device burst in progress at beat 3 with CPU store pending, reset asserted one cycle -> FSM in ARB, dev_rvalid=0, the CPU store is performed first after reset deasserts.
- With DATA_BUS_ARB_PERF_EN: 3 stalled CPU cycles and 5 device beats -> perf_stall_cycles=3, perf_dev_beats=5. Without the macro the bench compiles without these ports.
